// File: rtl/fetch_ifid_stage_if.sv
// Bundle of the fetch stage's instruction-memory handshake, IF/ID outputs
// and hazard/branch controls.
// master: the fetch stage. slave: its environment (imem, decode, hazard unit, EX).
interface fetch_ifid_stage_if;
  logic        stall_sel;
  logic        flush_sel;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  modport master (
    input  stall_sel, flush_sel, br_target, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall_sel, flush_sel, br_target, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_pc, if_inst, if_valid
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch stage plus IF/ID pipeline register of the RV32I core.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// Each returned word goes to IF/ID, or to a one-entry skid buffer while decode stalls.
// A flush redirects the PC, and any response still in flight is then discarded.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall/flush cycle counters.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_ifid_stage_if.master    bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic        deliver;
  logic [31:0] deliver_inst;
  logic        outstanding;

  assign bus.imem_req  = (state_q == S_REQ);
  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;

  // Next-state, PC, skid and IF/ID update; a flush overrides everything else.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    deliver      = 1'b0;
    deliver_inst = skid_q;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (!bus.stall_sel) begin
            deliver      = 1'b1;
            deliver_inst = bus.imem_rdata;
            state_d      = S_REQ;
          end else begin
            skid_d  = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!bus.stall_sel) begin
          deliver      = 1'b1;
          deliver_inst = skid_q;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase

    if (deliver) begin
      if_pc_d    = pc_q;
      if_inst_d  = deliver_inst;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end else if (!bus.stall_sel) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end

    // A response is still owed after this cycle if one was granted now, or one is
    // pending and has not arrived yet. A response landing in the flush cycle is
    // already consumed, so waiting for it in DROP would deadlock.
    outstanding = (state_q == S_REQ  && bus.imem_gnt) ||
                  (state_q == S_WAIT && !bus.imem_rvalid) ||
                  (state_q == S_DROP && !bus.imem_rvalid);

    if (bus.flush_sel) begin
      if_pc_d    = if_pc_q;
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
      pc_d       = {bus.br_target[31:2], 2'b00};
      skid_d     = 32'h0;
      state_d    = outstanding ? S_DROP : S_REQ;
    end
  end

  // State, PC, skid buffer and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      skid_q     <= 32'h0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Cycle counters for stall and flush activity; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (bus.stall_sel && !bus.flush_sel) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.flush_sel)                   perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed self-checking bench for fetch_ifid_stage.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// The DUT updates on the rising edge between them.
// u_dut0 uses the default RESET_PC; u_dut1 starts at 32'hFFFF_FFFC to exercise PC wrap.
module tb_fetch_ifid_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  fetch_ifid_stage_if bus0 ();
  fetch_ifid_stage_if bus1 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

  fetch_ifid_stage u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus0.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(stall_cnt0),
    .perf_flush_cnt(flush_cnt0)
`endif
  );

  fetch_ifid_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus1.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(stall_cnt1),
    .perf_flush_cnt(flush_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one full cycle: rising edge (DUT update), then falling edge (sample/drive point).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    {bus0.stall_sel, bus0.flush_sel, bus0.imem_gnt, bus0.imem_rvalid} = 4'b0;
    {bus1.stall_sel, bus1.flush_sel, bus1.imem_gnt, bus1.imem_rvalid} = 4'b0;
    bus0.br_target = 32'h0; bus0.imem_rdata = 32'h0;
    bus1.br_target = 32'h0; bus1.imem_rdata = 32'h0;

    // Scenario 1: bring up, reach WAIT, then reset mid-transaction.
    step();
    step();
    rst_n = 1'b1;
    step();                                   // BOOT -> REQ
    check("boot_req", {31'b0, bus0.imem_req}, 32'd1);
    bus0.imem_gnt = 1'b1;
    step();                                   // REQ -> WAIT
    bus0.imem_gnt = 1'b0;
    #2 rst_n = 1'b0;                          // asynchronous, mid-cycle
    bus0.imem_rvalid = 1'b1;                  // response in flight is dropped
    bus0.imem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("rst_inst",  bus0.if_inst, NOP);
    check("rst_valid", {31'b0, bus0.if_valid}, 32'd0);
    check("rst_req",   {31'b0, bus0.imem_req}, 32'd0);
    check("rst_pc",    bus0.if_pc, 32'h0);
    step();
    bus0.imem_rvalid = 1'b0;
    rst_n = 1'b1;
    #1 check("post_rst_req0", {31'b0, bus0.imem_req}, 32'd0);
    step();                                   // edge 1: BOOT -> REQ
    check("post_rst_req1", {31'b0, bus0.imem_req}, 32'd1);
    check("post_rst_addr", bus0.imem_addr, 32'h0);

    // Scenario 2: straight-line fetch, one instruction per two cycles.
    bus0.imem_gnt = 1'b1;
    step();                                   // grant -> WAIT
    check("s2_wait_req", {31'b0, bus0.imem_req}, 32'd0);
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h4031_02b3;
    step();                                   // deliver #0
    check("s2_pc0",    bus0.if_pc, 32'h0);
    check("s2_inst0",  bus0.if_inst, 32'h4031_02b3);
    check("s2_valid0", {31'b0, bus0.if_valid}, 32'd1);
    check("s2_addr1",  bus0.imem_addr, 32'h4);
    bus0.imem_rvalid = 1'b0; bus0.imem_gnt = 1'b1;
    step();                                   // grant -> WAIT, IF/ID bubble
    check("s2_bubble_valid", {31'b0, bus0.if_valid}, 32'd0);
    check("s2_bubble_inst",  bus0.if_inst, NOP);
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h0010_0093;
    step();                                   // deliver #1, two cycles after #0
    check("s2_pc1",    bus0.if_pc, 32'h4);
    check("s2_inst1",  bus0.if_inst, 32'h0010_0093);
    check("s2_valid1", {31'b0, bus0.if_valid}, 32'd1);

    // Scenario 3: stall for two cycles arriving together with rvalid.
    bus0.imem_rvalid = 1'b0; bus0.imem_gnt = 1'b1;
    step();                                   // WAIT, IF/ID = {4, NOP, 0}
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h00A0_0113;
    bus0.stall_sel = 1'b1;
    step();                                   // word into skid, HOLD
    bus0.imem_rvalid = 1'b0;
    check("s3_hold_pc",    bus0.if_pc, 32'h4);
    check("s3_hold_valid", {31'b0, bus0.if_valid}, 32'd0);
    step();                                   // second stall cycle
    check("s3_hold_req",   {31'b0, bus0.imem_req}, 32'd0);
    check("s3_hold_inst",  bus0.if_inst, NOP);
    bus0.stall_sel = 1'b0;
    step();                                   // delivered from skid
    check("s3_pc",    bus0.if_pc, 32'h8);
    check("s3_inst",  bus0.if_inst, 32'h00A0_0113);
    check("s3_valid", {31'b0, bus0.if_valid}, 32'd1);
    check("s3_addr",  bus0.imem_addr, 32'hC);
    step();                                   // no duplicate delivery
    check("s3_nodup", {31'b0, bus0.if_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("s3_perf_stall", stall_cnt0, 32'd2);
`endif

    // Scenario 4: flush while WAIT; stale response discarded.
    bus0.imem_gnt = 1'b1;
    step();                                   // WAIT on pc 0xC
    bus0.imem_gnt = 1'b0; bus0.flush_sel = 1'b1; bus0.br_target = 32'h0000_0103;
    step();                                   // -> DROP, pc = 0x100
    check("s4_inst",  bus0.if_inst, NOP);
    check("s4_valid", {31'b0, bus0.if_valid}, 32'd0);
    check("s4_req",   {31'b0, bus0.imem_req}, 32'd0);
    bus0.flush_sel = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
    step();                                   // stale word dropped -> REQ
    bus0.imem_rvalid = 1'b0;
    check("s4_drop_valid", {31'b0, bus0.if_valid}, 32'd0);
    check("s4_drop_inst",  bus0.if_inst, NOP);
    check("s4_req2",  {31'b0, bus0.imem_req}, 32'd1);
    check("s4_addr",  bus0.imem_addr, 32'h0000_0100);

    // Scenario 5: flush and stall together while IF/ID holds a real instruction.
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'h0000_0033;
    step();                                   // deliver {0x100, 0x33, 1}
    check("s5_pre_valid", {31'b0, bus0.if_valid}, 32'd1);
    bus0.imem_rvalid = 1'b0;
    bus0.flush_sel = 1'b1; bus0.stall_sel = 1'b1; bus0.br_target = 32'h0000_0200;
    step();
    bus0.flush_sel = 1'b0; bus0.stall_sel = 1'b0;
    check("s5_valid", {31'b0, bus0.if_valid}, 32'd0);
    check("s5_inst",  bus0.if_inst, NOP);
    check("s5_pc",    bus0.if_pc, 32'h0000_0100);
    check("s5_addr",  bus0.imem_addr, 32'h0000_0200);
    check("s5_req",   {31'b0, bus0.imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("s5_perf_stall", stall_cnt0, 32'd2);
    check("s5_perf_flush", flush_cnt0, 32'd2);
`endif

    // Scenario 6: PC wrap on the second instance.
    check("s6_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_gnt = 1'b1;
    step();
    bus1.imem_gnt = 1'b0; bus1.imem_rvalid = 1'b1; bus1.imem_rdata = 32'h0000_0013;
    step();
    bus1.imem_rvalid = 1'b0;
    check("s6_pc",    bus1.if_pc, 32'hFFFF_FFFC);
    check("s6_valid", {31'b0, bus1.if_valid}, 32'd1);
    check("s6_addr1", bus1.imem_addr, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
